// File: rtl/class_loader_pkg.sv
// Shared types and helpers for the classifier feature loader.
package class_loader_pkg;

    typedef enum logic [1:0] {
        StIdle   = 2'd0,
        StLoad   = 2'd1,
        StSettle = 2'd2,
        StOut    = 2'd3
    } state_e;

    localparam int unsigned NFeatDefault = 51;
    localparam int unsigned InWDefault   = 8;

    // Number of input chunks needed to cover the feature bus.
    function automatic int unsigned calc_n_chunk(input int unsigned n_feat,
                                                 input int unsigned in_w);
        return (n_feat + in_w - 1) / in_w;
    endfunction

endpackage

// File: rtl/class_majority_vote.sv
// Combinational majority vote over N_VOTES classifier outputs; a tie resolves to 0.
module class_majority_vote #(
    parameter int unsigned N_VOTES = 3
) (
    input  logic [N_VOTES-1:0] votes,
    output logic               majority
);

    localparam int unsigned CNT_W = $clog2(N_VOTES + 1);

    logic [CNT_W-1:0] ones;

    // Popcount of the votes, then strict-majority compare.
    always_comb begin
        ones = '0;
        for (int unsigned i = 0; i < N_VOTES; i++) begin
            ones = ones + CNT_W'(votes[i]);
        end
        majority = (32'(ones) > (N_VOTES / 2));
    end

endmodule

// File: rtl/class_feature_loader.sv
// Streams byte chunks into a parallel feature bus, holds it for SETTLE cycles,
// then samples the classifier and returns the class on a valid/ready channel.
// Optional macro CLASS_LOADER_VOTE_EN: cls_i becomes N_TREES wide and is majority-voted.
module class_feature_loader
    import class_loader_pkg::*;
#(
    parameter int unsigned N_FEAT  = NFeatDefault,
    parameter int unsigned IN_W    = InWDefault,
    parameter int unsigned SETTLE  = 2,
    parameter int unsigned N_TREES = 3,
    localparam int unsigned N_CHUNK = calc_n_chunk(N_FEAT, IN_W),
`ifdef CLASS_LOADER_VOTE_EN
    localparam int unsigned CLS_W = N_TREES
`else
    localparam int unsigned CLS_W = 1
`endif
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              s_valid,
    output logic              s_ready,
    input  logic [IN_W-1:0]   s_data,
    input  logic              s_last,
    output logic [N_FEAT-1:0] feat_o,
    input  logic [CLS_W-1:0]  cls_i,
    output logic              m_valid,
    input  logic              m_ready,
    output logic              m_class,
    output logic              m_err
);

    localparam int unsigned CNT_W = (N_CHUNK > 1) ? $clog2(N_CHUNK) : 1;

    if (SETTLE < 1 || SETTLE > 15) begin : g_bad_settle
        $error("SETTLE must be in 1..15");
    end
    if (N_TREES < 1) begin : g_bad_trees
        $error("N_TREES must be at least 1");
    end

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [3:0]         settle_q, settle_d;
    logic               err_q, err_d;
    logic               drop_q, drop_d;
    logic [N_FEAT-1:0]  feat_q, feat_d;
    logic               s_ready_q, s_ready_d;
    logic               m_valid_q, m_valid_d;
    logic               m_class_q, m_class_d;
    logic               m_err_q, m_err_d;
    logic               cls_vote;

`ifdef CLASS_LOADER_VOTE_EN
    class_majority_vote #(
        .N_VOTES (N_TREES)
    ) u_vote (
        .votes    (cls_i),
        .majority (cls_vote)
    );
`else
    assign cls_vote = cls_i;
`endif

    // State and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= StIdle;
            cnt_q     <= '0;
            settle_q  <= '0;
            err_q     <= 1'b0;
            drop_q    <= 1'b0;
            feat_q    <= '0;
            s_ready_q <= 1'b0;
            m_valid_q <= 1'b0;
            m_class_q <= 1'b0;
            m_err_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            settle_q  <= settle_d;
            err_q     <= err_d;
            drop_q    <= drop_d;
            feat_q    <= feat_d;
            s_ready_q <= s_ready_d;
            m_valid_q <= m_valid_d;
            m_class_q <= m_class_d;
            m_err_q   <= m_err_d;
        end
    end

    // Next-state: chunk assembly, framing checks, settle timer and result handshake.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        settle_d  = settle_q;
        err_d     = err_q;
        drop_d    = drop_q;
        feat_d    = feat_q;
        s_ready_d = s_ready_q;
        m_valid_d = m_valid_q;
        m_class_d = m_class_q;
        m_err_d   = m_err_q;

        case (state_q)
            StIdle: begin
                state_d   = StLoad;
                s_ready_d = 1'b1;
            end
            StLoad: begin
                if (s_valid && s_ready_q) begin
                    if (drop_q) begin
                        // Tail of an over-long vector: discard through its s_last.
                        if (s_last) begin
                            drop_d = 1'b0;
                        end
                    end else begin
                        // Bits past N_FEAT in the final chunk fall off here.
                        for (int unsigned i = 0; i < N_FEAT; i++) begin
                            if ((i / IN_W) == 32'(cnt_q)) begin
                                feat_d[i] = s_data[i % IN_W];
                            end
                        end
                        if (cnt_q == CNT_W'(N_CHUNK - 1)) begin
                            err_d     = !s_last;
                            drop_d    = !s_last;
                            state_d   = StSettle;
                            s_ready_d = 1'b0;
                            settle_d  = '0;
                        end else if (s_last) begin
                            err_d     = 1'b1;
                            state_d   = StSettle;
                            s_ready_d = 1'b0;
                            settle_d  = '0;
                        end else begin
                            cnt_d = cnt_q + 1'b1;
                        end
                    end
                end
            end
            StSettle: begin
                if (settle_q == 4'(SETTLE - 1)) begin
                    m_class_d = cls_vote;
                    m_err_d   = err_q;
                    m_valid_d = 1'b1;
                    state_d   = StOut;
                end else begin
                    settle_d = settle_q + 4'd1;
                end
            end
            StOut: begin
                if (m_ready) begin
                    m_valid_d = 1'b0;
                    cnt_d     = '0;
                    s_ready_d = 1'b1;
                    state_d   = StLoad;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    assign s_ready = s_ready_q;
    assign feat_o  = feat_q;
    assign m_valid = m_valid_q;
    assign m_class = m_class_q;
    assign m_err   = m_err_q;

endmodule
